// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state encoding,
// opcode constants, mux-select encodings and the control-vector payload.
package multi_cycle_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_IARITH = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_ECALL  = 7'b1110011;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_ALU    = 2'd2;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd1;
    localparam logic [1:0] ALUOP_BRANCH = 2'd2;

    // One cycle's worth of datapath control.
    typedef struct packed {
        logic       pc_write;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op_sel;
        logic       retire;
        logic       is_halted;
    } ctrl_t;

    // Opcodes that need an execute step; anything else (besides ECALL)
    // is treated as a NOP and goes straight to write-back.
    function automatic logic needs_ex(input logic [OPC_W-1:0] op);
        case (op)
            OPC_RTYPE, OPC_IARITH, OPC_LOAD, OPC_STORE,
            OPC_BRANCH, OPC_JAL, OPC_JALR: needs_ex = 1'b1;
            default:                       needs_ex = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_fsm_decode.sv
// Pure combinational decoder: (state, opcode, alu_bcond, halt_req, mem_ready)
// -> control vector for the shared multi-cycle datapath.
//   i_state     current FSM state
//   i_opcode    IR[6:0]
//   i_alu_bcond branch comparison result
//   i_halt_req  ECALL halt request (x17==10)
//   i_mem_ready memory handshake
//   o_ctrl      control vector for this cycle
module mc_ctrl_decode
    import multi_cycle_pkg::*;
(
    input  state_t           i_state,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_alu_bcond,
    input  logic             i_halt_req,
    input  logic             i_mem_ready,
    output ctrl_t            o_ctrl
);

    logic w_is_load;
    logic w_is_store;

    assign w_is_load  = (i_opcode == OPC_LOAD);
    assign w_is_store = (i_opcode == OPC_STORE);

    // Moore-style decode per state; only the handshake/condition inputs
    // qualify strobes that fire on the completing cycle.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_IF: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ir_write = i_mem_ready;
            end
            ST_ID: begin
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.retire    = (i_opcode == OPC_ECALL) && i_halt_req;
            end
            ST_EX: begin
                case (i_opcode)
                    OPC_RTYPE: begin
                        o_ctrl.alu_src_a  = 1'b1;
                        o_ctrl.alu_src_b  = SRCB_B;
                        o_ctrl.alu_op_sel = ALUOP_FUNCT;
                    end
                    OPC_IARITH: begin
                        o_ctrl.alu_src_a  = 1'b1;
                        o_ctrl.alu_src_b  = SRCB_IMM;
                        o_ctrl.alu_op_sel = ALUOP_FUNCT;
                    end
                    OPC_LOAD, OPC_STORE, OPC_JALR: begin
                        o_ctrl.alu_src_a  = 1'b1;
                        o_ctrl.alu_src_b  = SRCB_IMM;
                    end
                    OPC_BRANCH: begin
                        o_ctrl.alu_src_a  = 1'b1;
                        o_ctrl.alu_src_b  = SRCB_B;
                        o_ctrl.alu_op_sel = ALUOP_BRANCH;
                        // Target was computed into ALUOut during ID.
                        o_ctrl.pc_write   = i_alu_bcond;
                        o_ctrl.pc_source  = i_alu_bcond;
                        o_ctrl.retire     = i_alu_bcond;
                    end
                    OPC_JAL: begin
                        // Link value PC+4 comes live from the ALU.
                        o_ctrl.alu_src_b  = SRCB_FOUR;
                        o_ctrl.reg_write  = 1'b1;
                        o_ctrl.wb_sel     = WB_ALU;
                        o_ctrl.pc_write   = 1'b1;
                        o_ctrl.pc_source  = 1'b1;
                        o_ctrl.retire     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.mem_read  = w_is_load;
                o_ctrl.mem_write = w_is_store;
                if (i_mem_ready) begin
                    o_ctrl.mdr_write = w_is_load;
                    if (w_is_store) begin
                        o_ctrl.pc_write  = 1'b1;
                        o_ctrl.alu_src_b = SRCB_FOUR;
                        o_ctrl.retire    = 1'b1;
                    end
                end
            end
            ST_WB: begin
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.retire    = 1'b1;
                case (i_opcode)
                    OPC_RTYPE, OPC_IARITH: begin
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.wb_sel    = WB_ALUOUT;
                    end
                    OPC_LOAD: begin
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.wb_sel    = WB_MDR;
                    end
                    OPC_JALR: begin
                        // ALUOut holds rs1+imm; the live ALU gives PC+4 for rd.
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.wb_sel    = WB_ALU;
                        o_ctrl.pc_source = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                o_ctrl.is_halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// Control FSM for the shared multi-cycle RV32I datapath: state register,
// next-state logic, retired-instruction counter and output gating.
//   clk, reset (async, active-low)
//   opcode, alu_bcond, halt_req, mem_ready : sequencing inputs
//   pc_write .. alu_op_sel                 : datapath strobes / selects
//   retire, inst_count, is_halted          : retirement and halt status
module multi_cycle_ctrl_fsm
    import multi_cycle_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             alu_bcond,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op_sel,
    output logic             retire,
    output logic [CNT_W-1:0] inst_count,
    output logic             is_halted
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_inst_count;
    ctrl_t            w_ctrl;
    ctrl_t            w_ctrl_out;

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_alu_bcond (alu_bcond),
        .i_halt_req  (halt_req),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IF: begin
                if (mem_ready) w_state_nxt = ST_ID;
            end
            ST_ID: begin
                if (opcode == OPC_ECALL) begin
                    w_state_nxt = halt_req ? ST_HALT : ST_WB;
                end else if (needs_ex(opcode)) begin
                    w_state_nxt = ST_EX;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_EX: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: w_state_nxt = ST_MEM;
                    OPC_BRANCH:          w_state_nxt = alu_bcond ? ST_IF : ST_WB;
                    OPC_JAL:             w_state_nxt = ST_IF;
                    default:             w_state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    w_state_nxt = (opcode == OPC_STORE) ? ST_IF : ST_WB;
                end
            end
            ST_WB:   w_state_nxt = ST_IF;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IF;
        endcase
    end

    // Retired-instruction counter; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst_count <= '0;
        end else if (w_ctrl.retire) begin
            r_inst_count <= r_inst_count + CNT_W'(1);
        end
    end

    // No strobe may escape while reset is held, even mid-transaction.
    assign w_ctrl_out = reset ? w_ctrl : '0;

    assign pc_write   = w_ctrl_out.pc_write;
    assign pc_source  = w_ctrl_out.pc_source;
    assign i_or_d     = w_ctrl_out.i_or_d;
    assign mem_read   = w_ctrl_out.mem_read;
    assign mem_write  = w_ctrl_out.mem_write;
    assign ir_write   = w_ctrl_out.ir_write;
    assign mdr_write  = w_ctrl_out.mdr_write;
    assign reg_write  = w_ctrl_out.reg_write;
    assign wb_sel     = w_ctrl_out.wb_sel;
    assign alu_src_a  = w_ctrl_out.alu_src_a;
    assign alu_src_b  = w_ctrl_out.alu_src_b;
    assign alu_op_sel = w_ctrl_out.alu_op_sel;
    assign retire     = w_ctrl_out.retire;
    assign is_halted  = w_ctrl_out.is_halted;
    assign inst_count = r_inst_count;

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// Bench for multi_cycle_ctrl_fsm. Each instruction is scripted as the list of
// per-cycle control vectors it must produce; a compare process checks the DUT
// against that list on every falling edge. A narrow counter exercises wrap.
module tb_multi_cycle_ctrl_fsm;

    localparam int unsigned CW = 3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic          pc_write;
        logic          pc_source;
        logic          i_or_d;
        logic          mem_read;
        logic          mem_write;
        logic          ir_write;
        logic          mdr_write;
        logic          reg_write;
        logic [1:0]    wb_sel;
        logic          alu_src_a;
        logic [1:0]    alu_src_b;
        logic [1:0]    alu_op_sel;
        logic          retire;
        logic          is_halted;
        logic [CW-1:0] inst_count;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          alu_bcond;
    logic          halt_req;
    logic          mem_ready;
    logic          pc_write;
    logic          pc_source;
    logic          i_or_d;
    logic          mem_read;
    logic          mem_write;
    logic          ir_write;
    logic          mdr_write;
    logic          reg_write;
    logic [1:0]    wb_sel;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    alu_op_sel;
    logic          retire;
    logic [CW-1:0] inst_count;
    logic          is_halted;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            n_cyc  = 0;
    int            cyc_no = 0;
    bit            chk_en = 1'b0;
    logic [CW-1:0] m_count;
    exp_t          exp_q[$];
    exp_t          c_exp;
    exp_t          c_act;

    always #5 clk = ~clk;

    multi_cycle_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .alu_bcond  (alu_bcond),
        .halt_req   (halt_req),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mdr_write  (mdr_write),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op_sel (alu_op_sel),
        .retire     (retire),
        .inst_count (inst_count),
        .is_halted  (is_halted)
    );

    function automatic exp_t actual();
        return {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mdr_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op_sel,
                retire, is_halted, inst_count};
    endfunction

    // Per-cycle compare against the scripted expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            cyc_no++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cycle_vector %0d: no expectation queued", cyc_no);
            end else begin
                c_exp = exp_q.pop_front();
                c_act = actual();
                if (c_act !== c_exp) begin
                    n_fail++;
                    $display("FAIL cycle_vector %0d: got %b expected %b",
                             cyc_no, c_act, c_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs, queue what the outputs must be, advance.
    task automatic cyc(input logic [6:0] op, input logic bc, input logic hr,
                       input logic rdy, input exp_t e);
        opcode    = op;
        alu_bcond = bc;
        halt_req  = hr;
        mem_ready = rdy;
        e.inst_count = m_count;
        exp_q.push_back(e);
        if (e.retire) m_count = m_count + CW'(1);
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Script one instruction from fetch to retirement.
    task automatic issue(input logic [6:0] op, input logic bc, input logic hr,
                         input int if_stall, input int mem_stall, output int cycles);
        exp_t       e;
        logic       wb;
        logic       wb_reg;
        logic       wb_pcs;
        logic [1:0] wb_s;
        n_cyc  = 0;
        wb     = 1'b0;
        wb_reg = 1'b0;
        wb_pcs = 1'b0;
        wb_s   = 2'd0;
        for (int i = 0; i < if_stall; i++) begin
            e = '0; e.mem_read = 1'b1;
            cyc(7'($urandom), 1'($urandom), 1'($urandom), 1'b0, e);
        end
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
        cyc(7'($urandom), bc, hr, 1'b1, e);
        e = '0; e.alu_src_b = 2'd2; e.retire = (op == OP_ECALL) && hr;
        cyc(op, bc, hr, 1'($urandom), e);
        case (op)
            OP_R, OP_I: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op_sel = 2'd1;
                e.alu_src_b = (op == OP_R) ? 2'd0 : 2'd2;
                cyc(op, bc, hr, 1'($urandom), e);
                wb = 1'b1; wb_reg = 1'b1; wb_s = 2'd0;
            end
            OP_LOAD, OP_STORE: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                cyc(op, bc, hr, 1'($urandom), e);
                for (int i = 0; i < mem_stall; i++) begin
                    e = '0; e.i_or_d = 1'b1;
                    e.mem_read = (op == OP_LOAD); e.mem_write = (op == OP_STORE);
                    cyc(op, bc, hr, 1'b0, e);
                end
                e = '0; e.i_or_d = 1'b1;
                e.mem_read = (op == OP_LOAD); e.mem_write = (op == OP_STORE);
                if (op == OP_LOAD) begin
                    e.mdr_write = 1'b1;
                    wb = 1'b1; wb_reg = 1'b1; wb_s = 2'd1;
                end else begin
                    e.pc_write = 1'b1; e.alu_src_b = 2'd1; e.retire = 1'b1;
                end
                cyc(op, bc, hr, 1'b1, e);
            end
            OP_JALR: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                cyc(op, bc, hr, 1'($urandom), e);
                wb = 1'b1; wb_reg = 1'b1; wb_s = 2'd2; wb_pcs = 1'b1;
            end
            OP_BRANCH: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_op_sel = 2'd2;
                if (bc) begin
                    e.pc_write = 1'b1; e.pc_source = 1'b1; e.retire = 1'b1;
                end
                cyc(op, bc, hr, 1'($urandom), e);
                wb = !bc;
            end
            OP_JAL: begin
                e = '0; e.alu_src_b = 2'd1; e.reg_write = 1'b1; e.wb_sel = 2'd2;
                e.pc_write = 1'b1; e.pc_source = 1'b1; e.retire = 1'b1;
                cyc(op, bc, hr, 1'($urandom), e);
            end
            OP_ECALL: wb = !hr;
            default:  wb = 1'b1;
        endcase
        if (wb) begin
            e = '0; e.alu_src_b = 2'd1; e.pc_write = 1'b1; e.retire = 1'b1;
            e.reg_write = wb_reg; e.wb_sel = wb_s; e.pc_source = wb_pcs;
            cyc(op, bc, hr, 1'($urandom), e);
        end
        cycles = n_cyc;
    endtask

    initial begin
        int   cy;
        exp_t e;
        reset     = 1'b0;
        opcode    = OP_R;
        alu_bcond = 1'b0;
        halt_req  = 1'b0;
        mem_ready = 1'b1;
        m_count   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("outputs_in_reset", 32'(actual()), 32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        issue(OP_R, 1'b0, 1'b0, 0, 0, cy);      chk("lat_rtype", cy, 4);
        chk("count_after_rtype", 32'(inst_count), 32'd1);
        issue(OP_I, 1'b1, 1'b0, 0, 0, cy);      chk("lat_iarith", cy, 4);
        issue(OP_LOAD, 1'b0, 1'b0, 2, 3, cy);   chk("lat_load_stalled", cy, 10);
        issue(OP_STORE, 1'b0, 1'b1, 0, 0, cy);  chk("lat_store", cy, 4);
        issue(OP_BRANCH, 1'b1, 1'b0, 0, 0, cy); chk("lat_branch_taken", cy, 3);
        issue(OP_BRANCH, 1'b0, 1'b0, 0, 0, cy); chk("lat_branch_not_taken", cy, 4);
        issue(OP_JAL, 1'b0, 1'b0, 0, 0, cy);    chk("lat_jal", cy, 3);
        issue(OP_JALR, 1'b1, 1'b0, 0, 0, cy);   chk("lat_jalr", cy, 4);
        issue(OP_LUI, 1'b0, 1'b1, 0, 0, cy);    chk("lat_unknown", cy, 3);
        issue(OP_ECALL, 1'b0, 1'b0, 0, 0, cy);  chk("lat_ecall_no_halt", cy, 3);
        // 10 retirements on a 3-bit counter: wrapped once, now at 2.
        chk("count_wrapped", 32'(inst_count), 32'd2);

        issue(OP_ECALL, 1'b0, 1'b1, 1, 0, cy);  chk("lat_ecall_halt", cy, 3);
        for (int i = 0; i < 20; i++) begin
            e = '0; e.is_halted = 1'b1;
            cyc(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), e);
        end
        chk("count_after_halt", 32'(inst_count), 32'd3);
        chk("halted_flag", 32'(is_halted), 32'd1);

        // Reset out of HALT.
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("halt_cleared_by_reset", 32'(is_halted), 32'd0);
        chk("count_cleared_by_reset", 32'(inst_count), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        m_count = '0;
        chk_en  = 1'b1;

        // STORE interrupted by reset while stalled in MEM.
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
        cyc(OP_R, 1'b0, 1'b0, 1'b1, e);
        e = '0; e.alu_src_b = 2'd2;
        cyc(OP_STORE, 1'b0, 1'b0, 1'b1, e);
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        cyc(OP_STORE, 1'b0, 1'b0, 1'b1, e);
        e = '0; e.i_or_d = 1'b1; e.mem_write = 1'b1;
        cyc(OP_STORE, 1'b0, 1'b0, 1'b0, e);
        chk_en    = 1'b0;
        opcode    = OP_STORE;
        mem_ready = 1'b0;
        #1;
        chk("store_stall_mem_write", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        chk("mem_write_drops_async", 32'(mem_write), 32'd0);
        chk("outputs_zero_async", 32'(actual()), 32'd0);
        @(posedge clk);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("outputs_zero_held_reset", 32'(actual()), 32'd0);
        reset   = 1'b1;
        m_count = '0;
        chk_en  = 1'b1;

        issue(OP_R, 1'b0, 1'b0, 0, 0, cy);      chk("lat_rtype_after_reset", cy, 4);
        chk("count_after_reset_rtype", 32'(inst_count), 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl_fsm.md
Name: multi_cycle_ctrl_fsm

Overview:
Moore-style control FSM that sequences the shared multi-cycle RV32I datapath. The datapath has one ALU, one unified instruction/data memory, and IR, MDR, A, B and ALUOut registers. Each instruction is stepped through IF/ID/EX/MEM/WB, stalling on the memory ready handshake. The block also issues the halt on ECALL and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  7  IR[6:0]; valid from ID onward, ignored in IF
alu_bcond  in  1  branch-condition result from ALU; sampled in EX of a branch
halt_req  in  1  x17==10 from register file; sampled in ID of an ECALL
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  PC load strobe
pc_source  out  1  0 = live ALU result, 1 = ALUOut register
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load strobe
mdr_write  out  1  MDR load strobe
reg_write  out  1  register-file write enable
wb_sel  out  2  write-back data: 0 = ALUOut, 1 = MDR, 2 = live ALU result
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  0 = B, 1 = constant 4, 2 = immediate
alu_op_sel  out  2  0 = ADD, 1 = FUNCT (funct3/funct7 decoded), 2 = BRANCH compare
retire  out  1  one-cycle pulse in the last cycle of each instruction
inst_count  out  CNT_W  retired instructions since reset
is_halted  out  1  high in HALT state

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT. Outputs not listed for a state are 0.
- IF:
  - mem_read=1, i_or_d=0.
  - Hold while mem_ready=0.
  - In the mem_ready=1 cycle: ir_write=1, then go to ID.
- ID:
  - ALU computes PC+imm into ALUOut (src_a=0, src_b=2, ADD).
  - ECALL (1110011): halt_req=1 -> retire=1, go to HALT. halt_req=0 -> go to WB.
  - Unknown opcode -> WB (executes as NOP).
  - All other opcodes -> EX.
- EX:
  - R-type (0110011): src_a=1, src_b=0, FUNCT -> WB.
  - I-arith (0010011): src_a=1, src_b=2, FUNCT -> WB.
  - LOAD (0000011) / STORE (0100011): src_a=1, src_b=2, ADD -> MEM.
  - JALR (1100111): src_a=1, src_b=2, ADD -> WB.
  - BRANCH (1100011): src_a=1, src_b=0, BRANCH.
    - alu_bcond=1 -> pc_write=1, pc_source=1, retire=1, go to IF.
    - alu_bcond=0 -> WB.
  - JAL (1101111): src_a=0, src_b=1, ADD, reg_write=1, wb_sel=2, pc_write=1, pc_source=1, retire=1 -> IF.
- MEM:
  - i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - Hold while mem_ready=0; request lines stay stable throughout the stall.
  - LOAD, mem_ready=1 cycle: mdr_write=1 -> WB.
  - STORE, mem_ready=1 cycle: pc_write=1, pc_source=0, src_a=0, src_b=1, ADD, retire=1 -> IF.
- WB:
  - Always: src_a=0, src_b=1, ADD, pc_write=1, pc_source=0, retire=1 -> IF.
  - Exception: JALR uses pc_source=1.
  - reg_write=1 with wb_sel: 0 for R/I-arith, 1 for LOAD, 2 for JALR.
  - reg_write=0 for not-taken branch, ECALL and unknown opcodes.
- HALT: absorbing state; is_halted=1; all strobes 0 regardless of inputs. Left only by reset.
- Latencies with mem_ready tied to 1:
  - R/I-arith, JALR, not-taken branch: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JAL, taken branch, non-halting ECALL: 3 cycles.
  - Each mem_ready=0 cycle adds 1.
- inst_count increments on the clock edge ending any retire=1 cycle; wraps from all-ones to 0.
- Reset low (asynchronous, any state including a stall):
  - State goes to IF, inst_count=0, is_halted=0.
  - All outputs forced to 0 combinationally while reset=0, so no strobes during reset.
  - First IF request appears in the first cycle after reset release.

Decomposition:
- Shared package multi_cycle_pkg:
  - state enum (IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5).
  - RV32I opcode constants.
  - Encodings for wb_sel, alu_src_b and alu_op_sel.
- One natural sub-module: mc_ctrl_decode, a pure combinational (state, opcode, alu_bcond, mem_ready) -> output-vector decoder.
- Top level holds the state register, next-state logic and counter.

Test Plan:
- R-type add, mem_ready=1: states IF,ID,EX,WB over 4 cycles. WB cycle has reg_write=1, wb_sel=0, pc_write=1, retire=1. inst_count 0 -> 1.
- LOAD with mem_ready low 2 cycles in IF and 3 cycles in MEM: 10 cycles total. ir_write and mdr_write each pulse exactly once. mem_read held stable throughout both stalls. WB has wb_sel=1.
- BRANCH, alu_bcond=1: 3 cycles, EX has pc_write=1, pc_source=1. BRANCH, alu_bcond=0: 4 cycles, WB has reg_write=0, pc_source=0.
- JAL: 3 cycles, EX has reg_write=1, wb_sel=2, pc_source=1. JALR: 4 cycles, WB has reg_write=1, wb_sel=2, pc_source=1.
- ECALL, halt_req=1: is_halted=1 from the cycle after ID, inst_count +1, zero strobes for the next 20 cycles of random inputs. ECALL, halt_req=0: IF,ID,WB in 3 cycles, no reg_write.
- Assert reset low mid-stall in MEM of a STORE: mem_write drops in the same cycle without a clock edge. After release, IF with mem_read=1, inst_count=0.
